// File: rtl/cpu_bus_tracer_if.sv
// CPU snoop and trace-drain signals shared by the cpu side, the tracer and the log consumer.
interface cpu_bus_tracer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0]      a;
  logic [DATA_W-1:0]      din;
  logic [DATA_W-1:0]      dout;
  logic                   rd;
  logic                   wr;
  logic                   done;
  logic                   fault;
  logic                   tr_valid;
  logic                   tr_ready;
  logic [ADDR_W+DATA_W:0] tr_data;

  // Tracer side: snoops the cpu, sources the trace stream.
  modport slave (
    input  a, din, dout, rd, wr, done, fault, tr_ready,
    output tr_valid, tr_data
  );

  modport master (
    output a, din, dout, rd, wr, done, fault, tr_ready,
    input  tr_valid, tr_data
  );
endinterface

// File: rtl/cpu_bus_tracer.sv
// Bus-trace capture for the cpu core: logs accesses into a circular buffer, stops on a
// trigger or on done, then drains the log oldest-first over a valid/ready port.
module cpu_bus_tracer #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned POST_TRIG = 16,
  parameter int unsigned WDOG_W    = 20
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  cpu_bus_tracer_if.slave            bus_io,
  input  logic                       arm_i,
  input  logic [ADDR_W-1:0]          trig_addr_i,
  input  logic [ADDR_W-1:0]          trig_mask_i,
  input  logic [WDOG_W-1:0]          wdog_limit_i,
  output logic [1:0]                 state_o,
  output logic [2:0]                 cause_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       wrapped_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned EntW = 1 + ADDR_W + DATA_W;

  localparam logic [2:0] CauseNone  = 3'd0;
  localparam logic [2:0] CauseAddr  = 3'd1;
  localparam logic [2:0] CauseFault = 3'd2;
  localparam logic [2:0] CauseWdog  = 3'd3;
  localparam logic [2:0] CauseDone  = 3'd4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StPost    = 2'd2,
    StStopped = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          cause_q, cause_d;
  logic [PtrW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                wrapped_q, wrapped_d;
  logic [PtrW-1:0]     post_q, post_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                rd_prev_q, wr_prev_q, fault_prev_q;
  logic                rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                skid_vld_q, skid_vld_d;
  logic [EntW-1:0]     skid_q;
  logic [EntW-1:0]     mem_q [DEPTH];

  logic                wr_edge, rd_edge_raw, rd_edge, any_edge, fault_edge;
  logic                capturing, commit, addr_match, pop, wdog_hit;
  logic [EntW-1:0]     commit_entry;
  logic [ADDR_W-1:0]   commit_addr;

  assign wr_edge     = bus_io.wr & ~wr_prev_q;
  assign rd_edge_raw = bus_io.rd & ~rd_prev_q;
  assign rd_edge     = rd_edge_raw & ~wr_edge;
  assign any_edge    = wr_edge | rd_edge_raw;
  assign fault_edge  = bus_io.fault & ~fault_prev_q;
  assign capturing   = (state_q == StArmed) || (state_q == StPost);

  // A read commits the cycle after its edge, so a write edge landing on that cycle is
  // parked for one cycle; strobe edges are >=2 cycles apart so one slot is enough.
  always_comb begin
    commit       = 1'b0;
    commit_entry = '0;
    if (capturing && !arm_i) begin
      if (rd_pend_q) begin
        commit       = 1'b1;
        commit_entry = {1'b0, rd_addr_q, bus_io.din};
      end else if (skid_vld_q) begin
        commit       = 1'b1;
        commit_entry = skid_q;
      end else if (wr_edge) begin
        commit       = 1'b1;
        commit_entry = {1'b1, bus_io.a, bus_io.dout};
      end
    end
  end

  assign rd_pend_d  = capturing && !arm_i && rd_edge;
  assign skid_vld_d = capturing && !arm_i && wr_edge && rd_pend_q;

  assign commit_addr = commit_entry[ADDR_W+DATA_W-1:DATA_W];
  assign addr_match  = (trig_mask_i != '0) &&
                       ((commit_addr & trig_mask_i) == (trig_addr_i & trig_mask_i));

  assign bus_io.tr_valid = (state_q == StStopped) && (count_q != '0);
  assign bus_io.tr_data  = bus_io.tr_valid ? mem_q[rp_q] : '0;
  assign pop             = bus_io.tr_valid && bus_io.tr_ready;

  // Ring bookkeeping: commits only happen while capturing, pops only while stopped.
  always_comb begin
    wp_d      = wp_q;
    rp_d      = rp_q;
    count_d   = count_q;
    wrapped_d = wrapped_q;
    if (arm_i) begin
      wp_d      = '0;
      rp_d      = '0;
      count_d   = '0;
      wrapped_d = 1'b0;
    end else if (commit) begin
      wp_d = wp_q + 1'b1;
      if (count_q == CntW'(DEPTH)) begin
        rp_d      = rp_q + 1'b1;
        wrapped_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (pop) begin
      rp_d    = rp_q + 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    post_d   = post_q;
    wdog_d   = wdog_q;
    wdog_hit = 1'b0;
    if (arm_i) begin
      state_d = StArmed;
      cause_d = CauseNone;
      post_d  = '0;
      wdog_d  = '0;
    end else if (capturing) begin
      wdog_d   = any_edge ? '0 : wdog_q + 1'b1;
      wdog_hit = !any_edge && (wdog_limit_i != '0) && (wdog_d == wdog_limit_i);
      if (bus_io.done) begin
        state_d = StStopped;
        cause_d = CauseDone;
      end else if (state_q == StArmed && (fault_edge || (commit && addr_match))) begin
        cause_d = fault_edge ? CauseFault : CauseAddr;
        post_d  = PtrW'(POST_TRIG);
        state_d = (POST_TRIG == 0) ? StStopped : StPost;
      end else if (state_q == StArmed && wdog_hit) begin
        state_d = StStopped;
        cause_d = CauseWdog;
      end else if (state_q == StPost && commit) begin
        post_d = post_q - 1'b1;
        if (post_q <= PtrW'(1)) begin
          state_d = StStopped;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cause_q      <= CauseNone;
      wp_q         <= '0;
      rp_q         <= '0;
      count_q      <= '0;
      wrapped_q    <= 1'b0;
      post_q       <= '0;
      wdog_q       <= '0;
      rd_prev_q    <= 1'b0;
      wr_prev_q    <= 1'b0;
      fault_prev_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_addr_q    <= '0;
      skid_vld_q   <= 1'b0;
      skid_q       <= '0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      count_q      <= count_d;
      wrapped_q    <= wrapped_d;
      post_q       <= post_d;
      wdog_q       <= wdog_d;
      rd_prev_q    <= bus_io.rd;
      wr_prev_q    <= bus_io.wr;
      fault_prev_q <= bus_io.fault;
      rd_pend_q    <= rd_pend_d;
      rd_addr_q    <= bus_io.a;
      skid_vld_q   <= skid_vld_d;
      skid_q       <= {1'b1, bus_io.a, bus_io.dout};
    end
  end

  // Storage is not reset; tr_data is gated by tr_valid so stale contents never leak out.
  always_ff @(posedge clk_i) begin
    if (commit) begin
      mem_q[wp_q] <= commit_entry;
    end
  end

  assign state_o   = state_q;
  assign cause_o   = cause_q;
  assign count_o   = count_q;
  assign wrapped_o = wrapped_q;

endmodule

// File: tb/tb_cpu_bus_tracer.sv
// Directed self-checking bench for cpu_bus_tracer.
module tb_cpu_bus_tracer;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DEPTH     = 64;
  localparam int unsigned POST_TRIG = 16;
  localparam int unsigned WDOG_W    = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic [15:0] trig_addr, trig_mask;
  logic [19:0] wdog_limit;
  logic [1:0]  state;
  logic [2:0]  cause;
  logic [6:0]  count;
  logic        wrapped;
  int          n_checks = 0;
  int          n_fail   = 0;

  cpu_bus_tracer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cpu_bus_tracer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .WDOG_W(WDOG_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus_io(bus), .arm_i(arm), .trig_addr_i(trig_addr),
    .trig_mask_i(trig_mask), .wdog_limit_i(wdog_limit), .state_o(state), .cause_o(cause),
    .count_o(count), .wrapped_o(wrapped)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_pulse();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
    bus.a = addr; bus.dout = data; bus.wr = 1'b1; tick();
    bus.wr = 1'b0; tick();
  endtask

  task automatic pulse_done();
    bus.done = 1'b1; tick(); bus.done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    n_checks++; if (cause !== 3'd0) begin n_fail++; $display("FAIL reset_cause got %0d want 0", cause); end
    n_checks++; if (count !== 7'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (wrapped !== 1'b0) begin n_fail++; $display("FAIL reset_wrapped got %b want 0", wrapped); end
    n_checks++; if (bus.tr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.tr_valid); end
    n_checks++; if (bus.tr_data !== 25'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus.tr_data); end
  endtask

  task automatic test_basic_writes();
    logic [24:0] exp;
    arm_pulse();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL basic_armed got %0d want 1", state); end
    for (int i = 0; i < 5; i++) do_write(16'hC000 + 16'(i), 8'h11 + 8'(i));
    pulse_done();
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL basic_state got %0d want 3", state); end
    n_checks++; if (cause !== 3'd4) begin n_fail++; $display("FAIL basic_cause got %0d want 4", cause); end
    n_checks++; if (count !== 7'd5) begin n_fail++; $display("FAIL basic_count got %0d want 5", count); end
    for (int i = 0; i < 5; i++) begin
      exp = {1'b1, 16'hC000 + 16'(i), 8'h11 + 8'(i)};
      n_checks++; if (bus.tr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid%0d got %b want 1", i, bus.tr_valid); end
      n_checks++; if (bus.tr_data !== exp) begin n_fail++; $display("FAIL basic_data%0d got %h want %h", i, bus.tr_data, exp); end
      bus.tr_ready = 1'b1; tick(); bus.tr_ready = 1'b0;
    end
    n_checks++; if (bus.tr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty got %b want 0", bus.tr_valid); end
    n_checks++; if (count !== 7'd0) begin n_fail++; $display("FAIL basic_count0 got %0d want 0", count); end
  endtask

  task automatic test_read_and_collision();
    arm_pulse();
    bus.a = 16'h0000; bus.rd = 1'b1; tick();
    bus.rd = 1'b0; bus.din = 8'h31; tick();
    // rd and wr rising together: only the write is logged
    bus.a = 16'h1234; bus.dout = 8'hAB; bus.rd = 1'b1; bus.wr = 1'b1; tick();
    bus.rd = 1'b0; bus.wr = 1'b0; bus.din = 8'h77; tick();
    pulse_done();
    n_checks++; if (count !== 7'd2) begin n_fail++; $display("FAIL read_count got %0d want 2", count); end
    n_checks++; if (bus.tr_data !== {1'b0, 16'h0000, 8'h31}) begin n_fail++; $display("FAIL read_entry got %h want 0000031", bus.tr_data); end
    bus.tr_ready = 1'b1; tick(); bus.tr_ready = 1'b0;
    n_checks++; if (bus.tr_data !== {1'b1, 16'h1234, 8'hAB}) begin n_fail++; $display("FAIL collide_entry got %h want 11234ab", bus.tr_data); end
    bus.tr_ready = 1'b1; tick(); bus.tr_ready = 1'b0;
    n_checks++; if (bus.tr_valid !== 1'b0) begin n_fail++; $display("FAIL read_empty got %b want 0", bus.tr_valid); end
  endtask

  task automatic test_wrap();
    arm_pulse();
    for (int i = 0; i < 70; i++) do_write(16'h1000 + 16'(i), 8'(i));
    pulse_done();
    n_checks++; if (count !== 7'd64) begin n_fail++; $display("FAIL wrap_count got %0d want 64", count); end
    n_checks++; if (wrapped !== 1'b1) begin n_fail++; $display("FAIL wrap_flag got %b want 1", wrapped); end
    n_checks++; if (bus.tr_data !== {1'b1, 16'h1006, 8'h06}) begin n_fail++; $display("FAIL wrap_first got %h want 1100606", bus.tr_data); end
    bus.tr_ready = 1'b1;
    for (int i = 0; i < 63; i++) tick();
    n_checks++; if (bus.tr_data !== {1'b1, 16'h1045, 8'h45}) begin n_fail++; $display("FAIL wrap_last got %h want 1104545", bus.tr_data); end
    tick(); bus.tr_ready = 1'b0;
    n_checks++; if (bus.tr_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_empty got %b want 0", bus.tr_valid); end
  endtask

  task automatic test_addr_trigger();
    logic [24:0] exp;
    trig_addr = 16'hFF50; trig_mask = 16'hFFFF;
    arm_pulse();
    for (int i = 0; i < 3; i++) do_write(16'h2000 + 16'(i), 8'(i));
    do_write(16'hFF50, 8'h50);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL addr_post got %0d want 2", state); end
    n_checks++; if (cause !== 3'd1) begin n_fail++; $display("FAIL addr_cause got %0d want 1", cause); end
    for (int j = 0; j < 20; j++) do_write(16'h3000 + 16'(j), 8'h80 + 8'(j));
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL addr_stop got %0d want 3", state); end
    n_checks++; if (count !== 7'd20) begin n_fail++; $display("FAIL addr_count got %0d want 20", count); end
    for (int k = 0; k < 20; k++) begin
      if (k < 3)       exp = {1'b1, 16'h2000 + 16'(k), 8'(k)};
      else if (k == 3) exp = {1'b1, 16'hFF50, 8'h50};
      else             exp = {1'b1, 16'h3000 + 16'(k - 4), 8'h80 + 8'(k - 4)};
      n_checks++; if (bus.tr_data !== exp) begin n_fail++; $display("FAIL addr_data%0d got %h want %h", k, bus.tr_data, exp); end
      bus.tr_ready = 1'b1; tick(); bus.tr_ready = 1'b0;
    end
    n_checks++; if (bus.tr_valid !== 1'b0) begin n_fail++; $display("FAIL addr_empty got %b want 0", bus.tr_valid); end
    trig_mask = 16'h0000;
  endtask

  task automatic test_fault_post();
    arm_pulse();
    do_write(16'h5000, 8'h01); do_write(16'h5001, 8'h02);
    bus.fault = 1'b1; tick(); bus.fault = 1'b0;
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL fault_post got %0d want 2", state); end
    n_checks++; if (cause !== 3'd2) begin n_fail++; $display("FAIL fault_cause got %0d want 2", cause); end
    for (int j = 0; j < 15; j++) do_write(16'h6000 + 16'(j), 8'(j));
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL fault_still_post got %0d want 2", state); end
    do_write(16'h600F, 8'h0F);
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL fault_stop got %0d want 3", state); end
    n_checks++; if (count !== 7'd18) begin n_fail++; $display("FAIL fault_count got %0d want 18", count); end
  endtask

  task automatic test_wdog();
    wdog_limit = 20'd100;
    arm_pulse();
    do_write(16'h7000, 8'h70);
    for (int i = 0; i < 98; i++) tick();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL wdog_early got %0d want 1", state); end
    tick();
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL wdog_stop got %0d want 3", state); end
    n_checks++; if (cause !== 3'd3) begin n_fail++; $display("FAIL wdog_cause got %0d want 3", cause); end
    n_checks++; if (count !== 7'd1) begin n_fail++; $display("FAIL wdog_count got %0d want 1", count); end
    wdog_limit = 20'd0;
  endtask

  task automatic test_back_to_back();
    arm_pulse();
    for (int i = 0; i < 3; i++) do_write(16'h4000 + 16'(i), 8'h40 + 8'(i));
    bus.fault = 1'b1; bus.done = 1'b1; tick(); bus.fault = 1'b0; bus.done = 1'b0;
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL fd_state got %0d want 3", state); end
    n_checks++; if (cause !== 3'd4) begin n_fail++; $display("FAIL fd_cause got %0d want 4", cause); end
    n_checks++; if (count !== 7'd3) begin n_fail++; $display("FAIL fd_count got %0d want 3", count); end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (bus.tr_valid !== 1'b1 || bus.tr_data !== {1'b1, 16'h4000, 8'h40}) begin
        n_fail++; $display("FAIL hold_stable%0d got %b/%h want 1/1400040", i, bus.tr_valid, bus.tr_data);
      end
      tick();
    end
    bus.tr_ready = 1'b1; tick(); bus.tr_ready = 1'b0;
    n_checks++; if (bus.tr_data !== {1'b1, 16'h4001, 8'h41}) begin n_fail++; $display("FAIL hold_next got %h want 1400141", bus.tr_data); end
    arm_pulse();
    n_checks++; if (state !== 2'd1 || count !== 7'd0 || cause !== 3'd0 || bus.tr_valid !== 1'b0) begin
      n_fail++; $display("FAIL rearm got st=%0d cnt=%0d cause=%0d v=%b want 1/0/0/0", state, count, cause, bus.tr_valid);
    end
    do_write(16'h8000, 8'h80);
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++; if (state !== 2'd0 || count !== 7'd0 || wrapped !== 1'b0 || bus.tr_data !== 25'd0) begin
      n_fail++; $display("FAIL mid_reset got st=%0d cnt=%0d wr=%b d=%h want 0/0/0/0", state, count, wrapped, bus.tr_data);
    end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; trig_addr = '0; trig_mask = '0; wdog_limit = '0;
    bus.a = '0; bus.din = '0; bus.dout = '0; bus.rd = 1'b0; bus.wr = 1'b0;
    bus.done = 1'b0; bus.fault = 1'b0; bus.tr_ready = 1'b0;
    test_reset();
    test_basic_writes();
    test_read_and_collision();
    test_wrap();
    test_addr_trigger();
    test_fault_post();
    test_wdog();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
